// File: rtl/iomem_wb_pkg.sv
// Shared definitions for the iomem-to-Wishbone bridge: FSM encoding, error data, address window width.
package iomem_wb_pkg;

    localparam int          WIN_W             = 8;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags expiry on the final one.
module wb_timeout_cnt #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Expiry is only meaningful in a cycle the caller is still waiting.
    assign o_expired = i_enable & (r_count == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/iomem_wb_bridge.sv
// picosoc iomem slave that turns each decoded transfer into one Wishbone classic cycle.
// Build option IOMEM_WB_TIMEOUT_EN adds a watchdog that forces an error completion in BUS.
module iomem_wb_bridge
    import iomem_wb_pkg::*;
#(
    parameter logic [WIN_W-1:0] BASE_ADDR      = 8'h04,
    parameter logic [15:0]      TIMEOUT_CYCLES = 16'd255,
    parameter logic [31:0]      ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [23:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        bus_err
);

    bridge_state_t r_state;
    bridge_state_t w_state_next;

    logic        w_hit;
    logic        w_in_bus;
    logic        w_timeout;
    logic        w_fail;
    logic        w_done;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [23:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rdata;
    logic        r_bus_err;

    // ready is blanked from the hit term so a request still held during DONE is not re-accepted.
    assign w_hit    = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE_ADDR);
    assign w_in_bus = (r_state == S_BUS);

`ifdef IOMEM_WB_TIMEOUT_EN
    logic w_expired;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .resetn   (resetn),
        .i_clear  ((r_state == S_IDLE) & w_hit),
        .i_enable (w_in_bus & ~wbm_ack_i & ~wbm_err_i),
        .o_expired(w_expired)
    );

    assign w_timeout = w_expired;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_fail = w_in_bus & (wbm_err_i | w_timeout);
    assign w_done = w_in_bus & (wbm_ack_i | wbm_err_i | w_timeout);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_state_next = S_BUS;
            S_BUS:   if (w_done) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= 24'h0;
            r_dat     <= 32'h0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && w_hit) begin
                r_we  <= |iomem_wstrb;
                r_sel <= (|iomem_wstrb) ? iomem_wstrb : 4'hF;
                r_adr <= iomem_addr[23:0];
                r_dat <= iomem_wdata;
            end
            if (w_done) begin
                r_rdata <= w_fail ? ERR_RDATA : (r_we ? 32'h0 : wbm_dat_i);
            end
            if (w_fail) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign iomem_ready = (r_state == S_DONE);
    assign iomem_rdata = r_rdata;
    assign wbm_cyc_o   = w_in_bus;
    assign wbm_stb_o   = w_in_bus;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign bus_err     = r_bus_err;

endmodule
